// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide for the MIPS datapath.
// One operand bit is processed per clock. The signed result is delivered
// in hi/lo together with a single-cycle done pulse, 33 cycles after the
// start request is sampled. A divide by zero is rejected at once with a
// one-cycle divByZero pulse.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             multOP,
    input  logic             divOP,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divByZero
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    logic [1:0]         state_reg;
    logic [5:0]         cnt_reg;

    // Architectural result registers and output flags
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               dbz_reg;

    // Sign bookkeeping captured at start
    logic               neg_result_reg;   // product / quotient must be negated
    logic               neg_rem_reg;      // remainder must be negated (dividend < 0)

    // Multiply working registers
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;

    // Divide working registers
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quot_reg;
    logic [WIDTH-1:0]   dvs_reg;

    // Operand magnitudes; the most negative value maps to itself, which is
    // exactly its magnitude when read as unsigned.
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               b_zero;
    logic               idle_like;

    // One shift-add step and the sign-corrected product
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_final;

    // One restoring-division step and the sign-corrected results
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quot_step;
    logic [WIDTH-1:0]   quot_final;
    logic [WIDTH-1:0]   rem_final;

    assign a_neg     = a[WIDTH-1];
    assign b_neg     = b[WIDTH-1];
    assign a_mag     = a_neg ? (~a + 1'b1) : a;
    assign b_mag     = b_neg ? (~b + 1'b1) : b;
    assign b_zero    = (b == '0);
    assign idle_like = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

    // Datapath for the current iteration of either operation
    always_comb begin
        acc_step   = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        prod_final = neg_result_reg ? (~acc_step + 1'b1) : acc_step;

        // Shift in the next dividend bit and try subtracting the divisor.
        // The partial remainder is always below the divisor, so bit WIDTH
        // of the difference is a clean borrow indicator.
        div_shifted = {rem_reg, quot_reg[WIDTH-1]};
        div_diff    = div_shifted - {1'b0, dvs_reg};
        div_fits    = ~div_diff[WIDTH];
        rem_step    = div_fits ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
        quot_step   = {quot_reg[WIDTH-2:0], div_fits};
        quot_final  = neg_result_reg ? (~quot_step + 1'b1) : quot_step;
        rem_final   = neg_rem_reg ? (~rem_step + 1'b1) : rem_step;
    end

    // Control FSM, iteration counter, working registers and result latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            dbz_reg        <= 1'b0;
            neg_result_reg <= 1'b0;
            neg_rem_reg    <= 1'b0;
            acc_reg        <= '0;
            mcand_reg      <= '0;
            mplier_reg     <= '0;
            rem_reg        <= '0;
            quot_reg       <= '0;
            dvs_reg        <= '0;
        end else begin
            done_reg <= 1'b0;
            dbz_reg  <= 1'b0;
            if (idle_like) begin
                // DONE samples starts exactly like IDLE, so back-to-back
                // operations run without a gap cycle.
                busy_reg <= 1'b0;
                cnt_reg  <= '0;
                if (multOP) begin
                    state_reg      <= ST_MULT;
                    busy_reg       <= 1'b1;
                    acc_reg        <= '0;
                    mcand_reg      <= {{WIDTH{1'b0}}, a_mag};
                    mplier_reg     <= b_mag;
                    neg_result_reg <= a_neg ^ b_neg;
                end else if (divOP && !b_zero) begin
                    state_reg      <= ST_DIV;
                    busy_reg       <= 1'b1;
                    rem_reg        <= '0;
                    quot_reg       <= a_mag;
                    dvs_reg        <= b_mag;
                    neg_result_reg <= a_neg ^ b_neg;
                    neg_rem_reg    <= a_neg;
                end else begin
                    state_reg <= ST_IDLE;
                    dbz_reg   <= divOP;
                end
            end else begin
                // MULT / DIV: start requests are ignored, not queued
                cnt_reg <= cnt_reg + 6'd1;
                if (state_reg == ST_MULT) begin
                    acc_reg    <= acc_step;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        hi_reg    <= prod_final[2*WIDTH-1:WIDTH];
                        lo_reg    <= prod_final[WIDTH-1:0];
                    end
                end else begin
                    rem_reg  <= rem_step;
                    quot_reg <= quot_step;
                    if (cnt_reg == LAST_ITER) begin
                        state_reg <= ST_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        hi_reg    <= rem_final;
                        lo_reg    <= quot_final;
                    end
                end
            end
        end
    end

    assign hi        = hi_reg;
    assign lo        = lo_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign divByZero = dbz_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors for mult_div_unit. The stimulus side
// pushes each expected response (kind, cycle, hi, lo) into a queue; a
// monitor pops and compares whenever done or divByZero is presented.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        multOP;
    logic        divOP;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        divByZero;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .multOP    (multOP),
        .divOP     (divOP),
        .a         (a),
        .b         (b),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero)
    );

    typedef struct {
        string       name;
        bit          is_dbz;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index; inputs driven while cyc == T are sampled at the edge
    // ending cycle T.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare every presented response against the queue head
    always @(negedge clk) begin
        if (!reset && (done || divByZero)) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_response: done=%0b divByZero=%0b hi=0x%08h lo=0x%08h cycle %0d",
                         done, divByZero, hi, lo, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %-10s cycle=%0d done=%0b dbz=%0b hi=0x%08h lo=0x%08h (want hi=0x%08h lo=0x%08h @%0d)",
                         e.name, cyc, done, divByZero, hi, lo, e.hi, e.lo, e.cyc);
                check({e.name, "_done"}, {63'd0, done}, {63'd0, !e.is_dbz});
                check({e.name, "_dbz"}, {63'd0, divByZero}, {63'd0, e.is_dbz});
                check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                check({e.name, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
                check({e.name, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive one start request for one cycle; returns the cycle T it was held in
    task automatic issue(input bit m, input bit d, input logic [31:0] av,
                         input logic [31:0] bv, output int t);
        t      = cyc;
        multOP = m;
        divOP  = d;
        a      = av;
        b      = bv;
        @(negedge clk);
        multOP = 1'b0;
        divOP  = 1'b0;
        a      = $urandom;
        b      = $urandom;
    endtask

    task automatic expect_result(input string name, input int t,
                                 input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.name = name; e.is_dbz = 1'b0; e.cyc = t + 33; e.hi = h; e.lo = l;
        exp_q.push_back(e);
    endtask

    // Bounded wait for the scoreboard to drain
    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Issue one complete operation whose result is known in advance
    task automatic run_op(input string name, input bit m, input bit d,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] h, input logic [31:0] l);
        int t;
        t = cyc + 1;
        @(negedge clk);
        expect_result(name, t, h, l);
        issue(m, d, av, bv, t);
        drain();
    endtask

    initial begin
        int   t;
        int   t2;
        exp_t e;
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        multOP = 1'b0;
        divOP  = 1'b0;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_flags", {61'd0, busy, done, divByZero}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 7 * -3 with busy / done timing
        expect_result("mul_7x-3", cyc, 32'hFFFFFFFF, 32'hFFFFFFEB);
        issue(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, t);
        check("mul_busy_T+1", {63'd0, busy}, 64'd1);
        wait_until(t + 32);
        check("mul_busy_T+32", {63'd0, busy}, 64'd1);
        wait_until(t + 33);
        check("mul_busy_T+33", {63'd0, busy}, 64'd0);
        wait_until(t + 34);
        check("mul_done_T+34", {63'd0, done}, 64'd0);
        drain();

        run_op("mul_min2", 1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_op("mul_m1m1", 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        run_op("div_-7/2", 1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_7/-2", 1'b0, 1'b1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_op("div_min/-1", 1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("div_-100/-7", 1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14);
        run_op("div_100/5", 1'b0, 1'b1, 32'd100, 32'd5, 32'd0, 32'd20);

        // Divide by zero: pulse only, HI/LO untouched
        e.name = "div_by0"; e.is_dbz = 1'b1; e.cyc = cyc + 1; e.hi = 32'd0; e.lo = 32'd20;
        exp_q.push_back(e);
        issue(1'b0, 1'b1, 32'd55, 32'd0, t);
        check("dbz_busy_T+1", {63'd0, busy}, 64'd0);
        repeat (40) begin
            @(negedge clk);
            if (busy) begin
                check("dbz_busy_low", {63'd0, busy}, 64'd0);
            end
        end
        check("dbz_hi_kept", {32'd0, hi}, 64'd0);
        check("dbz_lo_kept", {32'd0, lo}, 64'd20);
        drain();

        // Start request during MULT is ignored; restart in DONE is accepted
        expect_result("mul_6x7", cyc, 32'd0, 32'd42);
        issue(1'b1, 1'b0, 32'd6, 32'd7, t);
        wait_until(t + 5);
        divOP = 1'b1;
        b     = 32'd0;
        @(negedge clk);
        divOP = 1'b0;
        wait_until(t + 33);
        expect_result("mul_-5x9", cyc, 32'hFFFFFFFF, 32'hFFFFFFD3);
        issue(1'b1, 1'b0, 32'hFFFFFFFB, 32'd9, t2);
        wait_until(t + 67);
        check("b2b_result_drained", 64'(exp_q.size()), 64'd0);
        drain();

        // Simultaneous multOP/divOP with b = 0: multiply wins, no divByZero
        run_op("mul+div", 1'b1, 1'b1, 32'd3, 32'd0, 32'd0, 32'd0);
        run_op("div_100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);

        // Reset mid-divide: everything cleared, no done afterwards
        issue(1'b0, 1'b1, 32'd1000, 32'd7, t);
        wait_until(t + 10);
        reset = 1'b1;
        @(negedge clk);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        check("abort_flags", {61'd0, busy, done, divByZero}, 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_hi_held", {32'd0, hi}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
